// File: rtl/coo_csr_writer.sv
// Turns a row-sorted (row, col) index stream into CSR row-pointer and packed
// column-index writes through one stallable word-write port.
module coo_csr_writer #(
  parameter int INDEX_WIDTH = 32,
  parameter int ADDR_WIDTH  = 48,
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_LOG2   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  ptr_base,
  input  logic [ADDR_WIDTH-1:0]  col_base,
  input  logic [INDEX_WIDTH-1:0] num_rows,
  input  logic                   index_push,
  input  logic [INDEX_WIDTH-1:0] row,
  input  logic [INDEX_WIDTH-1:0] col,
  input  logic                   flush,
  output logic                   wr_req,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_stall,
  output logic [INDEX_WIDTH-1:0] nnz,
  output logic                   done,
  output logic                   overflow,
  output logic                   order_err
);

  localparam int PW = INDEX_WIDTH + 1;
  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_RUN, S_PTR, S_FLUSH_COL, S_FLUSH_PTR, S_DONE
  } state_t;

  state_t state;

  logic [2*INDEX_WIDTH-1:0] mem [0:DEPTH-1];
  logic [FIFO_LOG2:0]       wptr, rptr;
  logic                     empty, full, pop, push_ok;
  logic [INDEX_WIDTH-1:0]   head_r, head_c;

  logic [ADDR_WIDTH-1:0]    ptr_b, col_b, k;
  logic [INDEX_WIDTH-1:0]   nrows_q, cur_row, lat;
  logic [PW-1:0]            p;
  logic                     lat_vld, flush_lat;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                  (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
  assign head_r = mem[rptr[FIFO_LOG2-1:0]][2*INDEX_WIDTH-1:INDEX_WIDTH];
  assign head_c = mem[rptr[FIFO_LOG2-1:0]][INDEX_WIDTH-1:0];

  // A stalled FSM consumes nothing, so pop only when RUN will actually take the head.
  assign pop     = (state == S_RUN) && !wr_stall && !empty && !(head_r > cur_row);
  assign push_ok = index_push && (!full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[FIFO_LOG2-1:0]] <= {row, col};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wptr      <= '0;
      rptr      <= '0;
      ptr_b     <= '0;
      col_b     <= '0;
      k         <= '0;
      nrows_q   <= '0;
      cur_row   <= '0;
      lat       <= '0;
      lat_vld   <= 1'b0;
      flush_lat <= 1'b0;
      p         <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      nnz       <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else if (start) begin
      state     <= S_INIT;
      wptr      <= '0;
      rptr      <= '0;
      ptr_b     <= ptr_base;
      col_b     <= col_base;
      nrows_q   <= num_rows;
      cur_row   <= '0;
      lat_vld   <= 1'b0;
      flush_lat <= 1'b0;
      wr_req    <= 1'b0;
      nnz       <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      if (index_push) begin
        if (push_ok) wptr <= wptr + (FIFO_LOG2+1)'(1);
        else         overflow <= 1'b1;
      end
      if (flush && state != S_IDLE) flush_lat <= 1'b1;

      if (!wr_stall) begin
        case (state)
          S_INIT: begin
            wr_req  <= 1'b1;
            wr_addr <= ptr_b;
            wr_data <= '0;
            cur_row <= '0;
            p       <= PW'(1);
            k       <= '0;
            state   <= S_RUN;
          end
          S_RUN: begin
            if (!empty) begin
              if (head_r > cur_row) begin
                state <= S_PTR;
              end else begin
                rptr <= rptr + (FIFO_LOG2+1)'(1);
                nnz  <= nnz + INDEX_WIDTH'(1);
                if (head_r < cur_row) order_err <= 1'b1;
                if (lat_vld) begin
                  wr_req  <= 1'b1;
                  wr_addr <= col_b + k;
                  wr_data <= {head_c, lat};
                  k       <= k + ADDR_WIDTH'(1);
                  lat_vld <= 1'b0;
                end else begin
                  lat     <= head_c;
                  lat_vld <= 1'b1;
                end
              end
            // A push landing this cycle must still be seen before flushing.
            end else if (flush_lat && !index_push) begin
              state <= S_FLUSH_COL;
            end
          end
          S_PTR: begin
            wr_req  <= 1'b1;
            wr_addr <= ptr_b + ADDR_WIDTH'(p);
            wr_data <= {{(DATA_WIDTH-INDEX_WIDTH){1'b0}}, nnz};
            p       <= p + PW'(1);
            cur_row <= cur_row + INDEX_WIDTH'(1);
            if (cur_row + INDEX_WIDTH'(1) == head_r) state <= S_RUN;
          end
          S_FLUSH_COL: begin
            if (lat_vld) begin
              wr_req  <= 1'b1;
              wr_addr <= col_b + k;
              wr_data <= {{(DATA_WIDTH-INDEX_WIDTH){1'b0}}, lat};
              k       <= k + ADDR_WIDTH'(1);
              lat_vld <= 1'b0;
            end
            state <= S_FLUSH_PTR;
          end
          S_FLUSH_PTR: begin
            if (p <= {1'b0, nrows_q}) begin
              wr_req  <= 1'b1;
              wr_addr <= ptr_b + ADDR_WIDTH'(p);
              wr_data <= {{(DATA_WIDTH-INDEX_WIDTH){1'b0}}, nnz};
              p       <= p + PW'(1);
              if (p == {1'b0, nrows_q}) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_coo_csr_writer.sv
// Table-driven bench for coo_csr_writer: constant expected write lists go into a
// scoreboard queue, and a negedge monitor pops and compares each write.
module tb_coo_csr_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] ptr_base = '0, col_base = '0;
  logic [31:0] num_rows = '0;
  logic        index_push = 1'b0;
  logic [31:0] row = '0, col = '0;
  logic        flush = 1'b0;
  logic        wr_req;
  logic [47:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_stall = 1'b0;
  logic [31:0] nnz;
  logic        done, overflow, order_err;

  coo_csr_writer #(.FIFO_LOG2(2)) dut (
    .clk(clk), .rst(rst), .start(start), .ptr_base(ptr_base), .col_base(col_base),
    .num_rows(num_rows), .index_push(index_push), .row(row), .col(col),
    .flush(flush), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_stall(wr_stall), .nnz(nnz), .done(done), .overflow(overflow),
    .order_err(order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               nrows, npush, stall_at, stall_len, nwr, exp_nnz;
    logic [5:0][31:0] rows, cols;
    logic [7:0][47:0] wa;
    logic [7:0][63:0] wd;
    bit               exp_ovf, exp_oerr;
  } vec_t;

  typedef struct { logic [47:0] a; logic [63:0] d; } wr_t;

  vec_t tv[5];
  wr_t  sbq[$];
  int   checks = 0, fails = 0;
  logic stall_q = 1'b0;

  always @(posedge clk) stall_q <= wr_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall_q) begin
      checks++;
      if (wr_req !== 1'b0) begin
        fails++;
        $display("FAIL wr_req_during_stall: got %b want 0", wr_req);
      end
    end
    if (wr_req === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got [%0d]=%0h want none", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (wr_addr !== e.a || wr_data !== e.d) begin
          fails++;
          $display("FAIL write: got [%0d]=%0h want [%0d]=%0h", wr_addr, wr_data, e.a, e.d);
        end
      end
    end
  end

  function automatic logic [63:0] cw(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

  function automatic void pu(input int t, input int i, input int r, input int c);
    tv[t].rows[i] = r;
    tv[t].cols[i] = c;
  endfunction

  function automatic void ew(input int t, input int i, input int a, input logic [63:0] d);
    tv[t].wa[i] = 48'(a);
    tv[t].wd[i] = d;
  endfunction

  function automatic void hdr(input int t, input int nr, input int np, input int sa,
                              input int sl, input int nw, input int en, input bit ov, input bit oe);
    tv[t].nrows = nr; tv[t].npush = np; tv[t].stall_at = sa; tv[t].stall_len = sl;
    tv[t].nwr = nw; tv[t].exp_nnz = en; tv[t].exp_ovf = ov; tv[t].exp_oerr = oe;
  endfunction

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int nr);
    ptr_base = 48'd100; col_base = 48'd200; num_rows = 32'(nr);
    index_push = 1'b0; flush = 1'b0; wr_stall = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_vec(input int t);
    for (int i = 0; i < tv[t].nwr; i++) sbq.push_back('{a: tv[t].wa[i], d: tv[t].wd[i]});
    pulse_start(tv[t].nrows);
    for (int c = 0; c < 300; c++) begin
      index_push = (c < tv[t].npush);
      row = (c < tv[t].npush) ? tv[t].rows[c] : 32'd0;
      col = (c < tv[t].npush) ? tv[t].cols[c] : 32'd0;
      flush = (c == tv[t].npush);
      wr_stall = (c >= tv[t].stall_at) && (c < tv[t].stall_at + tv[t].stall_len);
      cyc();
      if (done === 1'b1) break;
    end
    index_push = 1'b0; flush = 1'b0; wr_stall = 1'b0;
    cyc();
    cyc();
    chk($sformatf("v%0d_done", t), 64'(done), 64'd1);
    chk($sformatf("v%0d_pending_writes", t), 64'(sbq.size()), 64'd0);
    chk($sformatf("v%0d_nnz", t), 64'(nnz), 64'(tv[t].exp_nnz));
    chk($sformatf("v%0d_overflow", t), 64'(overflow), 64'(tv[t].exp_ovf));
    chk($sformatf("v%0d_order_err", t), 64'(order_err), 64'(tv[t].exp_oerr));
    sbq.delete();
  endtask

  initial begin
    // basic
    hdr(0, 3, 3, -1, 0, 6, 3, 1'b0, 1'b0);
    pu(0, 0, 0, 5); pu(0, 1, 0, 7); pu(0, 2, 2, 1);
    ew(0, 0, 100, 64'd0); ew(0, 1, 200, cw(7, 5)); ew(0, 2, 101, 64'd2);
    ew(0, 3, 102, 64'd2); ew(0, 4, 201, cw(0, 1)); ew(0, 5, 103, 64'd3);
    // empty trailing rows
    hdr(1, 4, 1, -1, 0, 6, 1, 1'b0, 1'b0);
    pu(1, 0, 1, 9);
    ew(1, 0, 100, 64'd0); ew(1, 1, 101, 64'd0); ew(1, 2, 200, cw(0, 9));
    ew(1, 3, 102, 64'd1); ew(1, 4, 103, 64'd1); ew(1, 5, 104, 64'd1);
    // basic with 5-cycle stall mid-stream
    tv[2] = tv[0];
    tv[2].stall_at = 2; tv[2].stall_len = 5;
    // overflow: stalled from the start, 6 pushes into a 4-deep FIFO
    hdr(3, 1, 6, 0, 10, 4, 4, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) pu(3, i, 0, i + 1);
    ew(3, 0, 100, 64'd0); ew(3, 1, 200, cw(2, 1)); ew(3, 2, 201, cw(4, 3)); ew(3, 3, 101, 64'd4);
    // order error
    hdr(4, 3, 2, -1, 0, 5, 2, 1'b0, 1'b1);
    pu(4, 0, 2, 1); pu(4, 1, 1, 3);
    ew(4, 0, 100, 64'd0); ew(4, 1, 101, 64'd0); ew(4, 2, 102, 64'd0);
    ew(4, 3, 200, cw(3, 1)); ew(4, 4, 103, 64'd2);

    rst = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst_wr_req", 64'(wr_req), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_nnz", 64'(nnz), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_order_err", 64'(order_err), 64'd0);
    rst = 1'b0;
    cyc();

    for (int t = 0; t < 5; t++) run_vec(t);

    // restart mid-RUN, then the basic matrix must come out unchanged
    sbq.push_back('{a: 48'd100, d: 64'd0});
    pulse_start(3);
    index_push = 1'b1; row = 0; col = 1;
    cyc();
    row = 0; col = 2;
    cyc();
    index_push = 1'b0;
    chk("restart_nnz_before", 64'(nnz), 64'd1);
    run_vec(0);

    // reset in the middle of row-pointer writes
    sbq.push_back('{a: 48'd100, d: 64'd0});
    sbq.push_back('{a: 48'd101, d: 64'd0});
    pulse_start(4);
    index_push = 1'b1; row = 3; col = 1;
    cyc();
    index_push = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_wr_req", 64'(wr_req), 64'd0);
    chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
    chk("midrst_wr_data", wr_data, 64'd0);
    chk("midrst_nnz", 64'(nnz), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_flags", 64'({overflow, order_err}), 64'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("midrst_pending_writes", 64'(sbq.size()), 64'd0);
    chk("midrst_idle_done", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/coo_csr_writer.md
Name: coo_csr_writer

Overview:
- Sits directly downstream of pattern_decoder and consumes its (row, col) index stream.
- Converts that stream, which is sorted by row, into CSR arrays in memory:
  - a row-pointer array, one 64-bit word per pointer;
  - a column-index array, two 32-bit columns packed per 64-bit word.
- Issues one word-addressed write per cycle through a single write port. That port has stall backpressure; an internal FIFO absorbs the decoder's unstallable stream.

Parameters:
INDEX_WIDTH, 32, width of row/col/count values
ADDR_WIDTH, 48, word address width
DATA_WIDTH, 64, write data width (must equal 2*INDEX_WIDTH)
FIFO_LOG2, 4, input FIFO depth = 2^FIFO_LOG2 entries

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset; one clock, all state sampled on rising edge
start  in  1  pulse; captures bases and num_rows, starts a new matrix
ptr_base  in  ADDR_WIDTH  word address of row_ptr[0]
col_base  in  ADDR_WIDTH  word address of first packed column word
num_rows  in  INDEX_WIDTH  matrix row count
index_push  in  1  valid for row/col (from pattern_decoder)
row  in  INDEX_WIDTH  row index
col  in  INDEX_WIDTH  column index
flush  in  1  pulse; end of index stream
wr_req  out  1  write valid
wr_addr  out  ADDR_WIDTH  write word address
wr_data  out  DATA_WIDTH  write data
wr_stall  in  1  memory cannot accept a write
nnz  out  INDEX_WIDTH  nonzeros consumed so far
done  out  1  level; all writes issued; cleared by start
overflow  out  1  sticky; push dropped because FIFO was full
order_err  out  1  sticky; row decreased

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE. Reset mid-operation abandons the matrix and issues no further writes.
- All outputs are registered.
- Write port:
  - A write is launched at an edge only if wr_stall is 0 at that edge. The launched write appears on wr_req/wr_addr/wr_data the following cycle.
  - When stall is sampled 1, wr_req is 0 the following cycle and the FSM holds.
  - At most one write per cycle.
- Input FIFO:
  - index_push writes {row,col} every cycle it is high, unless the FIFO is full. In that case the entry is dropped and overflow is set.
  - A simultaneous pop and push on a full FIFO is accepted.
- start, in any state: clears the FIFO, nnz, cur_row, the half-word latch, done, overflow and order_err. It latches the bases and num_rows and enters INIT.
- FSM states:
  - IDLE.
  - INIT: write ptr_base <- 0. Then RUN with cur_row=0, p=ptr index 1, k=col word index 0.
  - RUN: if the FIFO is non-empty, examine the head entry (r, c):
    - r > cur_row: go to PTR without popping.
    - Otherwise pop the entry and nnz++. If the half-word latch is empty, latch c, with no write. If the latch is full, write col_base+k <- {c, latched}, with the latched column in the low half; then k++ and clear the latch.
    - r < cur_row: set order_err and process the entry as r == cur_row.
    - If the FIFO is empty and flush has been latched: go to FLUSH_COL.
  - PTR: each cycle write ptr_base+p <- zero-extended nnz, then p++ and cur_row++. Return to RUN when cur_row == r. Empty rows therefore repeat the pointer.
  - FLUSH_COL: if the latch holds a column, write col_base+k <- {0, latched}. Then FLUSH_PTR.
  - FLUSH_PTR: write ptr_base+p <- nnz while p <= num_rows, one per cycle. Then DONE.
  - DONE: done=1 until start or rst.
- flush is latched in any state, with no effect in IDLE. index_push after flush is latched is still accepted and processed before the flush completes.
- Rows >= num_rows are not checked. Their pointers are still written.
- Address arithmetic is modulo 2^ADDR_WIDTH. nnz wraps modulo 2^INDEX_WIDTH.

Test Plan:
- Basic: bases 100/200, num_rows=3; push (0,5),(0,7),(2,1) then flush; no stall.
  - Required writes: [100]=0, [200]={7,5}, [101]=2, [102]=2, [201]={0,1}, [103]=3.
  - done=1, nnz=3.
- Empty trailing rows: num_rows=4; push (1,9), flush.
  - Required writes: [100]=0, [101]=0, [200]={0,9}, [102]=1, [103]=1, [104]=1.
- Stall: the basic stimulus with wr_stall high for 5 cycles mid-stream.
  - Required: the identical write sequence with no duplicate, drop or reordering, and wr_req=0 during the stalled cycles.
- Overflow: FIFO_LOG2=2, wr_stall held 1, push 6 entries back-to-back.
  - Required: overflow=1, and exactly 4 entries are processed after the stall is released.
- Order error: push (2,1),(1,3).
  - Required: order_err=1, and col word {3,1} is written.
- Restart/reset: assert start mid-RUN, then run the basic stimulus.
  - Required: the output matches the basic case exactly.
  - rst mid-PTR: wr_req=0 the next cycle and all outputs 0.
